// File: rtl/dtcm_pkg.sv
// Shared encodings and defaults for the DTCM load/store unit.
package dtcm_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   localparam int DEF_DTCM_LAT = 2;
   localparam int DEF_TIMEOUT  = 15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_WR,
      ST_RESP
   } state_t;

   // Registered request fields that outlive the accept cycle.
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  lane;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/lsu_align.sv
// Sub-word lane handling: load extraction/extension, store merge, alignment check.
module lsu_align
   import dtcm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        uns,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged,
   output logic        misaligned
);

   localparam int NUM_LANES = 4;

   logic [7:0]           b;
   logic [15:0]          h;
   logic [NUM_LANES-1:0] be;
   logic [31:0]          wrep;

   assign b = word[{lane, 3'b000} +: 8];
   assign h = word[{lane[1], 4'b0000} +: 16];

   assign misaligned = (size == SZ_X) ||
                       (size == SZ_H && lane[0]) ||
                       (size == SZ_W && lane != 2'b00);

   always_comb begin
      load_data = word;
      case (size)
         SZ_B:    load_data = {{24{~uns & b[7]}}, b};
         SZ_H:    load_data = {{16{~uns & h[15]}}, h};
         default: load_data = word;
      endcase
   end

   // Store data is replicated across lanes so each lane just picks it or keeps memory.
   always_comb begin
      be   = '1;
      wrep = wdata;
      case (size)
         SZ_B: begin
            be   = 4'b0001 << lane;
            wrep = {4{wdata[7:0]}};
         end
         SZ_H: begin
            be   = lane[1] ? 4'b1100 : 4'b0011;
            wrep = {2{wdata[15:0]}};
         end
         default: begin
            be   = '1;
            wrep = wdata;
         end
      endcase
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word[8*i +: 8];
   end

endmodule

// File: rtl/dtcm_lsu.sv
// Load/store initiator for the word-only DTCM port; sub-word stores use read-modify-write.
module dtcm_lsu
   import dtcm_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int DTCM_LAT   = DEF_DTCM_LAT,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] dtcm_addr,
   output logic [DATA_WIDTH-1:0] dtcm_wdata,
   output logic                  dtcm_rw,
   input  logic [DATA_WIDTH-1:0] dtcm_rdata,
   input  logic                  dtcm_ready
);

   localparam int CNT_MAX = DTCM_LAT + TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t                state, state_n;
   logic [CNT_W-1:0]      cnt;
   req_t                  r;
   logic [ADDR_WIDTH-3:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic        idle, accept, rd_hit, rd_tmo, word_st;
   logic [1:0]  a_size, a_lane;
   logic        a_uns;
   logic [31:0] a_wdata, ld_data, mrg_data;
   logic        misal;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

   assign idle    = (state == ST_IDLE);
   assign accept  = idle & req_valid;
   assign word_st = req_we & (req_size == SZ_W);
   assign rd_hit  = (state == ST_RD_WAIT) && (cnt >= CNT_W'(DTCM_LAT)) && dtcm_ready;
   assign rd_tmo  = (state == ST_RD_WAIT) && !rd_hit && (cnt == CNT_W'(CNT_MAX));

   // The alignment check needs the live request; extraction/merge need the registered one.
   assign a_size  = idle ? req_size     : r.size;
   assign a_lane  = idle ? req_addr[1:0] : r.lane;
   assign a_uns   = idle ? req_unsigned : r.uns;
   assign a_wdata = idle ? req_wdata    : r.wdata;

   lsu_align u_align (
      .size       (a_size),
      .lane       (a_lane),
      .uns        (a_uns),
      .word       (dtcm_rdata),
      .wdata      (a_wdata),
      .load_data  (ld_data),
      .merged     (mrg_data),
      .misaligned (misal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (misal)        state_n = ST_RESP;
               else if (word_st) state_n = ST_WR;
               else              state_n = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (rd_hit)      state_n = r.we ? ST_WR : ST_RESP;
            else if (rd_tmo) state_n = ST_RESP;
         end
         ST_WR:   state_n = ST_RESP;
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         r       <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= '0;
            r       <= '{we: req_we, size: req_size, uns: req_unsigned,
                         lane: req_addr[1:0], wdata: req_wdata};
            rdata_q <= '0;
            err_q   <= misal;
            // Rejected requests leave the memory-side bus untouched.
            if (!misal) begin
               addr_q <= req_addr[ADDR_WIDTH-1:2];
               if (word_st) wdata_q <= req_wdata;
            end
         end
         if (state == ST_RD_WAIT) begin
            cnt <= cnt + CNT_W'(1);
            if (rd_hit) begin
               if (r.we) wdata_q <= mrg_data;
               else      rdata_q <= ld_data;
            end else if (rd_tmo) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign req_ready  = idle;
   assign resp_valid = (state == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign dtcm_addr  = {addr_q, 2'b00};
   assign dtcm_wdata = wdata_q;
   assign dtcm_rw    = (state == ST_WR);

endmodule

// File: doc/dtcm_lsu.md
# dtcm_lsu

Load/store initiator driving the data TCM's word-only port (`addr`/`wdata`/`rw` → `rdata`/`ready`) on behalf of the core's memory stage. Accepts byte, halfword and word loads and stores, performs read-modify-write for sub-word stores, and sign- or zero-extends load data. Flags misaligned accesses without touching memory. Sits between the execute/memory pipeline stage and `dtcm`.

## Interface
- `ADDR_WIDTH`, 12: DTCM byte-address width. Request address bits above this are ignored (aliased).
- `DATA_WIDTH`, 32: bus width. Only 32 is supported.
- `DTCM_LAT`, 2: wait cycles after a read is first driven before `rdata` is captured.
- `TIMEOUT`, 15: maximum extra wait cycles for `dtcm_ready` before an error response.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE. A request is accepted on `req_valid & req_ready`.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1: zero-extend loads.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, LSB-aligned.
- `resp_valid`  out  1: one-cycle completion pulse. No backpressure.
- `resp_rdata`  out  32: extended load data. 0 for stores and errors.
- `resp_err`  out  1: misaligned, illegal size, or timeout. Valid with `resp_valid`.
- `dtcm_addr`  out  ADDR_WIDTH: word-aligned address; bits [1:0] are always 0.
- `dtcm_wdata`  out  32: write data.
- `dtcm_rw`  out  1: 1 = write. High for exactly one cycle per write.
- `dtcm_rdata`  in  32: read data.
- `dtcm_ready`  in  1: DTCM ready.

## Operation
- **States:** IDLE, RD_WAIT, WR, RESP.
- **Accept:** on accept, register the request. A counter `cnt` is cleared on entry to RD_WAIT.
- **Misaligned or illegal:** half with `addr[0]=1`, word with `addr[1:0]!=0`, or size 11 → go straight to RESP with `resp_err=1`. No DTCM cycle is issued.
- **Word store:** IDLE → WR → RESP.
- **Loads and sub-word stores:** IDLE → RD_WAIT.
- **RD_WAIT:**
  - Drive the word address with `rw=0`; `cnt` increments each cycle.
  - When `cnt >= DTCM_LAT` and `dtcm_ready=1`, capture `dtcm_rdata`.
  - Load → RESP. Sub-word store → WR, carrying the merged word.
  - If `cnt == DTCM_LAT + TIMEOUT` without ready → RESP with `resp_err=1`.
- **WR:** one cycle with `rw=1` and `dtcm_wdata` set to the full word or the merged word → RESP.
- **RESP:** `resp_valid=1` for one cycle → IDLE.
- **Extraction:** lane = `addr[1:0]`; byte = `rdata[8*lane +: 8]`, half = `rdata[16*addr[1] +: 16]`. Sign-extend unless `req_unsigned`.
- **Merge:** replace the addressed byte or half of the captured word with `req_wdata[7:0]` or `req_wdata[15:0]`. Other lanes are preserved.
- **Outside RD_WAIT/WR:** `dtcm_rw=0` and `dtcm_addr` holds its last value; idle reads are harmless.

## Timing
- Accept edge = end of cycle 0.
- Latency to `resp_valid`, with `DTCM_LAT=2` and a ready DTCM:
  - Error: cycle 1.
  - Word store: cycle 2 (write in cycle 1).
  - Load: cycle 4 (capture at end of cycle 3).
  - Sub-word store: cycle 5 (write in cycle 4).
- Address and data stay stable through every RD_WAIT cycle.
- `req_ready` is low from cycle 1 through the RESP cycle. The next accept is possible the cycle after RESP.
- Reset values: `req_ready=1`; `resp_valid=0`; `resp_rdata=0`; `resp_err=0`; `dtcm_addr=0`; `dtcm_wdata=0`; `dtcm_rw=0`; state IDLE; `cnt=0`.
- Reset mid-operation: abandon immediately with no response. An RMW reset before WR leaves memory unchanged. `dtcm_rw` falls asynchronously.

## Structure
- Package `dtcm_pkg`:
  - Size encodings (`SZ_B`, `SZ_H`, `SZ_W`).
  - State enum.
  - Default `DTCM_LAT` and `TIMEOUT`.
- Sub-module `lsu_align`, combinational: byte/half extraction with sign/zero extension, store merge, and the misalignment check. Shared by load and RMW paths.
- The FSM, counter and registers live in `dtcm_lsu`.

## Test plan
- Word store `0xDEADBEEF` @ `0x010`, then word load @ `0x010` → store `resp_valid` at cycle 2 with `err=0`; load `resp_rdata=0xDEADBEEF` at cycle 4.
- With `0xDEADBEEF` @ `0x010`: signed byte load @ `0x013` → `0xFFFFFFDE`; unsigned half load @ `0x012` → `0x0000DEAD`; signed half load @ `0x010` → `0xFFFFBEEF`.
- Byte store `0x55` @ `0x011` over `0xDEADBEEF` → one `dtcm_rw` pulse in cycle 4 with `wdata=0xDEAD55EF`; later word load returns `0xDEAD55EF`.
- Word load @ `0x012`, half @ `0x005`, size 11 → `resp_valid` cycle 1 with `resp_err=1`; `dtcm_rw` never asserted.
- Hold `dtcm_ready=0` → `resp_err=1` at RD_WAIT cycle `DTCM_LAT+TIMEOUT`+1; then `dtcm_ready=1` and a load completes normally.
- Assert `rst_n=0` during RD_WAIT of a half store → outputs immediately at reset values; memory word unchanged; the next request completes normally.
